fifo_write_feeder: RTL and testbench

FIFO_WRITE_FEEDER -- requirements
Module: fifo_write_feeder

---
 rtl/fifo_write_feeder_if.sv | 24 ++
 rtl/fifo_write_feeder.sv | 145 ++++++++++++++
 tb/tb_fifo_write_feeder.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_write_feeder_if.sv
// fifo_write_feeder_if: upstream valid/ready stream plus FIFO write-side bus.
// master = feeder side, slave = upstream source / FIFO side.
interface fifo_write_feeder_if #(
   parameter int DATA_WIDTH = 1,
   parameter int LPM_WIDTHU = 4
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic                  wrreq;
   logic [DATA_WIDTH-1:0] data;
   logic [LPM_WIDTHU:0]   wrusedw;
   logic                  wrfull;

   modport master (
      input  in_valid, in_data, wrusedw, wrfull,
      output in_ready, wrreq, data
   );

   modport slave (
      output in_valid, in_data, wrusedw, wrfull,
      input  in_ready, wrreq, data
   );
endinterface

// File: rtl/fifo_write_feeder.sv
// fifo_write_feeder: accepts a valid/ready word stream into a 2-entry skid
// buffer and writes it into a FIFO, keeping HEADROOM words free.
// Optional statistics counters are built only when FIFO_WRITE_FEEDER_STATS_EN
// is defined; otherwise words_written/stall_cycles are tied to 0.
//
// state | meaning
// EMPTY | no word buffered
// ONE   | one word buffered (in head)
// TWO   | two words buffered (head, tail); upstream held off
module fifo_write_feeder #(
   parameter int DATA_WIDTH   = 1,
   parameter int LPM_NUMWORDS = 16,
   parameter int LPM_WIDTHU   = 4,
   parameter int HEADROOM     = 2
) (
   input  logic                 wrclk,
   input  logic                 aclr_n,
   fifo_write_feeder_if.master  bus,
   output logic                 overflow_err,
   output logic [31:0]          words_written,
   output logic [31:0]          stall_cycles
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   // Fill threshold; sum carries one extra bit so wrusedw + wrreq cannot wrap.
   localparam logic [LPM_WIDTHU+1:0] WR_LIMIT = (LPM_WIDTHU+2)'(LPM_NUMWORDS - HEADROOM);

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] head, head_nxt;
   logic [DATA_WIDTH-1:0] tail, tail_nxt;
   logic                  ready_q;
   logic                  wrreq_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [LPM_WIDTHU+1:0] fill_sum;
   logic                  can_write;
   logic                  push;
   logic                  pop;

   // wrreq_q is included so a write already in flight counts against the limit.
   assign fill_sum  = {1'b0, bus.wrusedw} + {{(LPM_WIDTHU+1){1'b0}}, wrreq_q};
   assign can_write = !bus.wrfull && (fill_sum < WR_LIMIT);
   assign push      = bus.in_valid && ready_q;
   assign pop       = (state != EMPTY) && can_write;

   assign bus.in_ready = ready_q;
   assign bus.wrreq    = wrreq_q;
   assign bus.data     = data_q;

   // State register, skid storage and registered write-side outputs.
   always_ff @(posedge wrclk or negedge aclr_n) begin
      if (!aclr_n) begin
         state   <= EMPTY;
         head    <= '0;
         tail    <= '0;
         ready_q <= 1'b0;
         wrreq_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state   <= state_nxt;
         head    <= head_nxt;
         tail    <= tail_nxt;
         ready_q <= (state_nxt != TWO);
         wrreq_q <= pop;
         if (pop) begin
            data_q <= head;
         end
      end
   end

   // Next state and buffer contents; head is always the oldest word.
   always_comb begin
      state_nxt = state;
      head_nxt  = head;
      tail_nxt  = tail;
      case (state)
         EMPTY: begin
            if (push) begin
               state_nxt = ONE;
               head_nxt  = bus.in_data;
            end
         end
         ONE: begin
            if (push && pop) begin
               head_nxt = bus.in_data;
            end else if (push) begin
               tail_nxt  = bus.in_data;
               state_nxt = TWO;
            end else if (pop) begin
               state_nxt = EMPTY;
            end
         end
         TWO: begin
            // in_ready is low here, so only a pop can occur.
            if (pop) begin
               head_nxt  = tail;
               state_nxt = ONE;
            end
         end
         default: begin
            state_nxt = EMPTY;
         end
      endcase
   end

   // Sticky flag: a write was strobed while the FIFO reported full.
   always_ff @(posedge wrclk or negedge aclr_n) begin
      if (!aclr_n) begin
         overflow_err <= 1'b0;
      end else if (wrreq_q && bus.wrfull) begin
         overflow_err <= 1'b1;
      end
   end

`ifdef FIFO_WRITE_FEEDER_STATS_EN
   logic [31:0] words_q;
   logic [31:0] stall_q;

   // Saturating counters of FIFO writes and of blocked cycles with data held.
   always_ff @(posedge wrclk or negedge aclr_n) begin
      if (!aclr_n) begin
         words_q <= '0;
         stall_q <= '0;
      end else begin
         if (wrreq_q && (words_q != 32'hFFFF_FFFF)) begin
            words_q <= words_q + 32'd1;
         end
         if ((state != EMPTY) && !can_write && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
         end
      end
   end

   assign words_written = words_q;
   assign stall_cycles  = stall_q;
`else
   assign words_written = 32'd0;
   assign stall_cycles  = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_write_feeder.sv
// Bench for fifo_write_feeder: FIFO fill model, scoreboard of accepted words
// compared against every FIFO write, and scenario tasks.
module tb_fifo_write_feeder;

`ifdef FIFO_WRITE_FEEDER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   localparam int DW = 8;

   logic        wrclk = 1'b0;
   logic        aclr_n = 1'b1;
   logic        overflow_err;
   logic [31:0] words_written;
   logic [31:0] stall_cycles;

   fifo_write_feeder_if #(.DATA_WIDTH(DW), .LPM_WIDTHU(4)) bus ();

   fifo_write_feeder #(
      .DATA_WIDTH(DW),
      .LPM_NUMWORDS(16),
      .LPM_WIDTHU(4),
      .HEADROOM(2)
   ) dut (
      .wrclk(wrclk),
      .aclr_n(aclr_n),
      .bus(bus),
      .overflow_err(overflow_err),
      .words_written(words_written),
      .stall_cycles(stall_cycles)
   );

   always #5 wrclk = ~wrclk;

   int total = 0;
   int bad = 0;
   int n_writes = 0;

   logic [4:0]    fifo_cnt;
   logic          force_full = 1'b0;
   logic          rd_en = 1'b0;
   logic          rd_now;
   logic          took = 1'b0;
   logic [DW-1:0] seq = '0;
   logic [DW-1:0] exp_w;
   logic [DW-1:0] sb[$];

   // FIFO model: wrusedw follows one cycle after each write; optional random reads.
   always @(posedge wrclk or negedge aclr_n) begin
      if (!aclr_n) begin
         fifo_cnt <= '0;
      end else begin
         rd_now = rd_en && (fifo_cnt != 0) && ($urandom_range(1) == 1);
         fifo_cnt <= fifo_cnt + 5'(bus.wrreq) - 5'(rd_now);
      end
   end

   assign bus.wrusedw = fifo_cnt;
   assign bus.wrfull  = (fifo_cnt >= 5'd16) || force_full;

   // Scoreboard: accepted words queued, every FIFO write checked in order.
   always @(negedge wrclk) begin
      took = 1'b0;
      if (aclr_n) begin
         if (bus.wrreq) begin
            n_writes++;
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_write: data=%0h written with no word pending", bus.data);
            end else begin
               exp_w = sb.pop_front();
               if (bus.data !== exp_w) begin
                  bad++;
                  $display("FAIL write_data: got %0h want %0h", bus.data, exp_w);
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            sb.push_back(bus.in_data);
            took = 1'b1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   task automatic reset_dut();
      force_full = 1'b0;
      rd_en = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      aclr_n = 1'b0;
      sb.delete();
      repeat (3) @(negedge wrclk);
      #1 aclr_n = 1'b1;
      took = 1'b0;
   endtask

   task automatic step();
      @(posedge wrclk);
      #1;
      if (took) seq++;
      bus.in_valid = 1'b1;
      bus.in_data = seq;
   endtask

   task automatic send_words(input int n, input int density);
      int sent = 0;
      int guard = 0;
      took = 1'b0;
      bus.in_valid = 1'b0;
      while (sent < n && guard < 3000) begin
         @(posedge wrclk);
         #1;
         if (took) begin
            sent++;
            seq++;
         end
         if (sent < n) begin
            bus.in_valid = ($urandom_range(99) < density);
            bus.in_data = bus.in_valid ? seq : DW'($urandom);
         end else begin
            bus.in_valid = 1'b0;
            bus.in_data = DW'($urandom);
         end
         guard++;
      end
      total++;
      if (sent != n) begin
         bad++;
         $display("FAIL send_timeout: accepted %0d want %0d", sent, n);
      end
   endtask

   task automatic wait_drain(input int limit);
      int g = 0;
      while (sb.size() != 0 && g < limit) begin
         @(negedge wrclk);
         g++;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout: %0d words still pending want 0", sb.size());
      end
      repeat (2) @(negedge wrclk);
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      aclr_n = 1'b1;
      #3 aclr_n = 1'b0;
      #1;
      total += 6;
      if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
      if (bus.wrreq !== 1'b0) begin bad++; $display("FAIL rst_wrreq: got %b want 0", bus.wrreq); end
      if (bus.data !== '0) begin bad++; $display("FAIL rst_data: got %0h want 0", bus.data); end
      if (overflow_err !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b want 0", overflow_err); end
      if (words_written !== 32'd0) begin bad++; $display("FAIL rst_words: got %0d want 0", words_written); end
      if (stall_cycles !== 32'd0) begin bad++; $display("FAIL rst_stall: got %0d want 0", stall_cycles); end
   endtask

   task automatic test_latency_and_fill();
      logic [31:0] s0;
      logic [31:0] exp_stall;
      reset_dut();
      aclr_n = 1'b0;
      seq = '0;
      bus.in_valid = 1'b1;
      bus.in_data = '0;
      @(negedge wrclk);
      #1 aclr_n = 1'b1;
      took = 1'b0;
      @(negedge wrclk);
      total += 2;
      if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ready_first_edge: got %b want 1", bus.in_ready); end
      if (bus.wrreq !== 1'b0) begin bad++; $display("FAIL wrreq_first_edge: got %b want 0", bus.wrreq); end
      step();
      @(negedge wrclk);
      total++;
      if (bus.wrreq !== 1'b0) begin bad++; $display("FAIL wrreq_accept_edge: got %b want 0", bus.wrreq); end
      for (int i = 0; i < 8; i++) begin
         step();
         @(negedge wrclk);
         total++;
         if (bus.wrreq !== 1'b1) begin bad++; $display("FAIL wrreq_stream[%0d]: got %b want 1", i, bus.wrreq); end
      end
      repeat (40) step();
      @(negedge wrclk);
      total += 5;
      if (fifo_cnt !== 5'd14) begin bad++; $display("FAIL fill_settle: got %0d want 14", fifo_cnt); end
      if (bus.wrreq !== 1'b0) begin bad++; $display("FAIL wrreq_at_limit: got %b want 0", bus.wrreq); end
      if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL ready_at_limit: got %b want 0", bus.in_ready); end
      if (overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_at_limit: got %b want 0", overflow_err); end
      if (words_written !== (STATS ? 32'd14 : 32'd0)) begin bad++; $display("FAIL words_at_limit: got %0d want %0d", words_written, STATS ? 14 : 0); end
      s0 = stall_cycles;
      step();
      @(negedge wrclk);
      exp_stall = STATS ? s0 + 32'd1 : 32'd0;
      total++;
      if (stall_cycles !== exp_stall) begin bad++; $display("FAIL stall_incr: got %0d want %0d", stall_cycles, exp_stall); end
   endtask

   task automatic test_reset_midstream();
      int w0;
      @(posedge wrclk);
      #2 aclr_n = 1'b0;
      sb.delete();
      bus.in_valid = 1'b0;
      #1;
      total += 4;
      if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got %b want 0", bus.in_ready); end
      if (bus.wrreq !== 1'b0) begin bad++; $display("FAIL mid_rst_wrreq: got %b want 0", bus.wrreq); end
      if (bus.data !== '0) begin bad++; $display("FAIL mid_rst_data: got %0h want 0", bus.data); end
      if (words_written !== 32'd0 || stall_cycles !== 32'd0) begin
         bad++;
         $display("FAIL mid_rst_counters: got %0d/%0d want 0/0", words_written, stall_cycles);
      end
      repeat (2) @(negedge wrclk);
      #1 aclr_n = 1'b1;
      w0 = n_writes;
      repeat (12) @(negedge wrclk);
      total++;
      if (n_writes != w0) begin bad++; $display("FAIL stale_writes: got %0d want 0", n_writes - w0); end
   endtask

   task automatic test_order();
      reset_dut();
      seq = '0;
      send_words(4, 100);
      wait_drain(50);
      total++;
      if (words_written !== (STATS ? 32'd4 : 32'd0)) begin bad++; $display("FAIL order_words: got %0d want %0d", words_written, STATS ? 4 : 0); end
   endtask

   task automatic test_random_backpressure();
      reset_dut();
      rd_en = 1'b1;
      seq = 8'h40;
      send_words(60, 60);
      wait_drain(400);
      total += 2;
      if (words_written !== (STATS ? 32'd60 : 32'd0)) begin bad++; $display("FAIL random_words: got %0d want %0d", words_written, STATS ? 60 : 0); end
      if (overflow_err !== 1'b0) begin bad++; $display("FAIL random_ovf: got %b want 0", overflow_err); end
      rd_en = 1'b0;
   endtask

   task automatic test_overflow();
      bit hit = 1'b0;
      reset_dut();
      seq = '0;
      for (int i = 0; i < 20 && !hit; i++) begin
         step();
         @(negedge wrclk);
         if (bus.wrreq) hit = 1'b1;
      end
      total++;
      if (!hit) begin bad++; $display("FAIL ovf_no_write: got no wrreq want wrreq"); end
      force_full = 1'b1;
      total++;
      if (overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_pre: got %b want 0", overflow_err); end
      @(posedge wrclk);
      #1 bus.in_valid = 1'b0;
      @(negedge wrclk);
      total++;
      if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow_err); end
      force_full = 1'b0;
      repeat (5) @(negedge wrclk);
      total++;
      if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
      wait_drain(100);
      @(posedge wrclk);
      #2 aclr_n = 1'b0;
      sb.delete();
      #1;
      total++;
      if (overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow_err); end
      @(negedge wrclk);
      #1 aclr_n = 1'b1;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      test_reset();
      test_latency_and_fill();
      test_reset_midstream();
      test_order();
      test_random_backpressure();
      test_overflow();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
